execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The module SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 The module SHALL expose these ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- working  in  1  CPU running; low blocks new acceptance
- in_valid  in  1  decode offers an operation
- in_ready  out  1  execute accepts the operation this cycle
- alufun  in  4  operation code
- cond  in  4  condition code for cnd
- set_cc  in  1  update condition codes
- valA  in  32  operand A / store data
- valB  in  32  operand B
- valC  in  32  immediate
- dstE_in  in  4  ALU destination register
- dstM_in  in  4  load destination register
- out_valid  out  1  result register holds a valid entry for the LSU
- out_ready  in  1  LSU consumes the entry
- valE  out  32  ALU result / memory address to LSU
- valA_out  out  32  store data to LSU
- dstE  out  4  forwarded dstE_in
- dstM  out  4  forwarded dstM_in
- cnd  out  1  condition evaluated for this entry
- cc  out  3  {ZF,SF,OF} register
- busy  out  1  multi-cycle operation in progress

Function
REQ-003 alufun decoding SHALL be: 0 ADD valB+valA; 1 SUB valB-valA; 2 AND; 3 XOR; 4 ADDC valB+valC; 5 MUL valB*valA (low 32 bits); 6 PASSC valE=valC; 7-15 valE=0.
REQ-004 All arithmetic SHALL be 32-bit two's complement with carry out discarded.
REQ-005 in_ready SHALL be working && state==IDLE && (!out_valid || out_ready).
REQ-006 A transfer SHALL occur on a rising edge where in_valid && in_ready.
REQ-007 A single-cycle operation (alufun != 5) SHALL load the output register on the transfer edge, giving out_valid=1 in the next cycle (1-cycle latency).
REQ-008 When out_valid && out_ready and no load occurs, out_valid SHALL clear on that edge; a simultaneous consume and load SHALL keep out_valid=1 with the new entry (full throughput).
REQ-009 The output register SHALL hold all fields unchanged while out_valid && !out_ready.
REQ-010 cnd SHALL be computed from cc before any update by the same operation: 0 always; 1 LE (SF^OF)|ZF; 2 L SF^OF; 3 E ZF; 4 NE !ZF; 5 GE !(SF^OF); 6 G !(SF^OF)&!ZF; 7-15 cnd=0.
REQ-011 On transfer with set_cc=1 and alufun in {0,1,2,3}, cc SHALL update on the transfer edge: ZF=(result==0), SF=result[31].
REQ-012 OF SHALL be: for ADD, the sign of A equals the sign of B and differs from the result; for SUB, the sign of A differs from the sign of B and the sign of the result differs from B; otherwise 0.
REQ-013 For MUL with set_cc=1, cc SHALL update when the result loads into the output register, with OF=0.
REQ-014 The FSM SHALL have three states:
- IDLE: on a MUL transfer, go to MUL with count=0.
- MUL: one shift-add step per cycle; go to DONE after the step at count==31.
- DONE: when !out_valid || out_ready, load the result and go to IDLE.
REQ-015 busy SHALL be 1 in states MUL and DONE.
REQ-016 With out_ready held at 1, MUL out_valid SHALL assert 33 cycles after the transfer edge.
REQ-017 working=0 SHALL block only acceptance; in-flight MUL and output handshakes SHALL proceed.

Reset
REQ-018 While reset=0, the block SHALL asynchronously force state=IDLE, count=0, out_valid=0, valE=0, valA_out=0, dstE=4'hF, dstM=4'hF, cnd=0, cc=3'b100, busy=0.
REQ-019 A reset asserted mid-MUL SHALL abort the operation, with no output entry produced.
REQ-020 The first transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-021 Macro EXE_MUL_EN: when defined, the MUL state machine and alufun=5 SHALL be present as above.
REQ-022 When EXE_MUL_EN is undefined, alufun=5 SHALL behave as a reserved code: 1-cycle latency, valE=0, no cc update, busy tied to 0, and no MUL/DONE states synthesised.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ADD: valA=7, valB=5, set_cc=1, out_ready=1 -> next cycle valE=12, cc=000.
- Overflow: SUB valA=1, valB=32'h80000000, set_cc=1 -> valE=32'h7FFFFFFF, OF=1, SF=0, ZF=0; a following op with cond=2 -> cnd=1.
- Backpressure: out_ready=0 with two back-to-back ADDs -> first entry held, in_ready=0; release out_ready -> second entry accepted the same cycle.
- MUL (EXE_MUL_EN): valA=6, valB=32'hFFFFFFFF -> busy for 32+ cycles, valE=32'hFFFFFFFA at transfer+33.
- Reset mid-MUL at cycle 10 -> out_valid=0, cc=100, dstE=F, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/execute_stage_if.sv
// Decode-to-execute and execute-to-LSU handshake bundle for execute_stage.
// slave is the execute side, master is the decode/LSU side.
interface execute_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alufun;
  logic [3:0]  cond;
  logic        set_cc;
  logic [31:0] valA;
  logic [31:0] valB;
  logic [31:0] valC;
  logic [3:0]  dstE_in;
  logic [3:0]  dstM_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] valE;
  logic [31:0] valA_out;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic        cnd;

  modport slave (
    input  in_valid, alufun, cond, set_cc, valA, valB, valC, dstE_in, dstM_in, out_ready,
    output in_ready, out_valid, valE, valA_out, dstE, dstM, cnd
  );

  modport master (
    output in_valid, alufun, cond, set_cc, valA, valB, valC, dstE_in, dstM_in, out_ready,
    input  in_ready, out_valid, valE, valA_out, dstE, dstM, cnd
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, condition codes, and a one-entry output register toward the LSU.
// Define EXE_MUL_EN to include the 32-step shift-add multiplier (alufun=5); otherwise code 5 is reserved.
module execute_stage (
  input  logic                clock,
  input  logic                reset,
  input  logic                working,
  execute_stage_if.slave      bus,
  output logic [2:0]          cc,
  output logic                busy
);
  logic [31:0] a, b, c;
  logic [31:0] result;
  logic        ofl;
  logic        cnd_now;
  logic        out_free;
  logic        take;
  logic        single_load;

  assign a        = bus.valA;
  assign b        = bus.valB;
  assign c        = bus.valC;
  assign out_free = !bus.out_valid || bus.out_ready;

  always_comb begin
    result = '0;
    ofl    = 1'b0;
    case (bus.alufun)
      4'd0: begin
        result = b + a;
        ofl    = (a[31] == b[31]) && (result[31] != a[31]);
      end
      4'd1: begin
        result = b - a;
        ofl    = (a[31] != b[31]) && (result[31] != b[31]);
      end
      4'd2:    result = a & b;
      4'd3:    result = a ^ b;
      4'd4:    result = b + c;
      4'd6:    result = c;
      default: result = '0;
    endcase
  end

  // cc is {ZF,SF,OF}; evaluated against the value before this operation updates it
  always_comb begin
    cnd_now = 1'b0;
    case (bus.cond)
      4'd0:    cnd_now = 1'b1;
      4'd1:    cnd_now = (cc[1] ^ cc[0]) | cc[2];
      4'd2:    cnd_now = cc[1] ^ cc[0];
      4'd3:    cnd_now = cc[2];
      4'd4:    cnd_now = !cc[2];
      4'd5:    cnd_now = !(cc[1] ^ cc[0]);
      4'd6:    cnd_now = !(cc[1] ^ cc[0]) && !cc[2];
      default: cnd_now = 1'b0;
    endcase
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] acc, mcand, mplier, p_valA;
  logic [3:0]  p_dstE, p_dstM;
  logic        p_set_cc, p_cnd;
  logic        mul_go, mul_load;

  assign bus.in_ready = working && (state == IDLE) && out_free;
  assign take         = bus.in_valid && bus.in_ready;
  assign mul_go       = take && (bus.alufun == 4'd5);
  assign single_load  = take && !mul_go;
  assign mul_load     = (state == DONE) && out_free;
  assign busy         = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_go) state_next = MUL;
      MUL:     if (count == 5'd31) state_next = DONE;
      DONE:    if (out_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cc cannot change while busy, so cnd is captured at acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      p_valA   <= '0;
      p_dstE   <= '1;
      p_dstM   <= '1;
      p_set_cc <= 1'b0;
      p_cnd    <= 1'b0;
    end else if (mul_go) begin
      count    <= '0;
      acc      <= '0;
      mcand    <= b;
      mplier   <= a;
      p_valA   <= a;
      p_dstE   <= bus.dstE_in;
      p_dstM   <= bus.dstM_in;
      p_set_cc <= bus.set_cc;
      p_cnd    <= cnd_now;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end
`else
  assign bus.in_ready = working && out_free;
  assign take         = bus.in_valid && bus.in_ready;
  assign single_load  = take;
  assign busy         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.valE      <= '0;
      bus.valA_out  <= '0;
      bus.dstE      <= '1;
      bus.dstM      <= '1;
      bus.cnd       <= 1'b0;
      cc            <= 3'b100;
    end else if (single_load) begin
      bus.out_valid <= 1'b1;
      bus.valE      <= result;
      bus.valA_out  <= a;
      bus.dstE      <= bus.dstE_in;
      bus.dstM      <= bus.dstM_in;
      bus.cnd       <= cnd_now;
      if (bus.set_cc && (bus.alufun <= 4'd3))
        cc <= {(result == 32'd0), result[31], ofl};
    end
`ifdef EXE_MUL_EN
    else if (mul_load) begin
      bus.out_valid <= 1'b1;
      bus.valE      <= acc;
      bus.valA_out  <= p_valA;
      bus.dstE      <= p_dstE;
      bus.dstM      <= p_dstM;
      bus.cnd       <= p_cnd;
      if (p_set_cc) cc <= {(acc == 32'd0), acc[31], 1'b0};
    end
`endif
    else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios then random traffic against a behavioural model.
// Expectations follow EXE_MUL_EN the same way the design does.
module tb_execute_stage;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       working = 1'b0;
  logic [2:0] cc;
  logic       busy;

  execute_stage_if bus();

  execute_stage dut (
    .clock   (clock),
    .reset   (reset),
    .working (working),
    .bus     (bus),
    .cc      (cc),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] valE;
    logic [31:0] valA_out;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        cnd;
    logic [2:0]  cc;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] mcc = 3'b100;
  int         checks = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cnd_model(input logic [3:0] cd, input logic [2:0] flags);
    bit zf = flags[2], sf = flags[1], of = flags[0];
    case (cd)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: signed results computed in 64 bits, overflow = result outside the 32-bit signed range
  task automatic model_accept(input logic [3:0] fn, input logic [3:0] cd, input logic sc,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [3:0] de, input logic [3:0] dm);
    exp_t e;
    longint sa, sbv, s;
    longint unsigned prod;
    logic [31:0] r = '0;
    logic of = 1'b0;
    bit upd = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.cnd = cnd_model(cd, mcc);
    case (fn)
      4'd0: begin s = sbv + sa; r = s[31:0]; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); upd = sc; end
      4'd1: begin s = sbv - sa; r = s[31:0]; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); upd = sc; end
      4'd2: begin r = a & b; upd = sc; end
      4'd3: begin r = a ^ b; upd = sc; end
      4'd4: r = b + c;
`ifdef EXE_MUL_EN
      4'd5: begin prod = {32'd0, a} * {32'd0, b}; r = prod[31:0]; upd = sc; end
`endif
      4'd6: r = c;
      default: r = '0;
    endcase
    if (upd) mcc = {(r == 32'd0), r[31], of};
    e.valE = r; e.valA_out = a; e.dstE = de; e.dstM = dm; e.cc = mcc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] fn, input logic [3:0] cd, input logic sc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.alufun = fn; bus.cond = cd; bus.set_cc = sc;
    bus.valA = a; bus.valB = b; bus.valC = c;
    bus.dstE_in = de; bus.dstM_in = dm;
  endtask

  task automatic send(input logic [3:0] fn, input logic [3:0] cd, input logic sc,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [3:0] de, input logic [3:0] dm);
    int n = 0;
    @(negedge clock);
    drive(fn, cd, sc, a, b, c, de, dm);
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clock); #1; n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      model_accept(fn, cd, sc, a, b, c, de, dm);
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_valE"}, bus.valE, 32'd0);
    chk({tag, "_valA_out"}, bus.valA_out, 32'd0);
    chk({tag, "_dstE"}, {28'd0, bus.dstE}, 32'hF);
    chk({tag, "_dstM"}, {28'd0, bus.dstM}, 32'hF);
    chk({tag, "_cnd"}, {31'd0, bus.cnd}, 32'd0);
    chk({tag, "_cc"}, {29'd0, cc}, 32'h4);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: an entry is consumed at the edge following a negedge where out_valid && out_ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_entry", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("valE", bus.valE, e.valE);
          chk("valA_out", bus.valA_out, e.valA_out);
          chk("dstE", {28'd0, bus.dstE}, {28'd0, e.dstE});
          chk("dstM", {28'd0, bus.dstM}, {28'd0, e.dstM});
          chk("cnd", {31'd0, bus.cnd}, {31'd0, e.cnd});
          chk("cc", {29'd0, cc}, {29'd0, e.cc});
        end
      end
    end
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'd0, 4'd0, 1'b0, '0, '0, '0, 4'd0, 4'd0);
    #12;
    check_reset_values("por");
    @(negedge clock);
    reset = 1'b1;
    working = 1'b1;
    #1 chk("first_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ADD 5+7
    send(4'd0, 4'd0, 1'b1, 32'd7, 32'd5, 32'd0, 4'd1, 4'd2);
    @(negedge clock); #1;
    chk("add_latency", {31'd0, bus.out_valid}, 32'd1);
    chk("add_valE", bus.valE, 32'd12);
    chk("add_cc", {29'd0, cc}, 32'h0);

    // Signed overflow on SUB, then LT condition observes it
    send(4'd1, 4'd0, 1'b1, 32'd1, 32'h8000_0000, 32'd0, 4'd3, 4'd4);
    @(negedge clock); #1;
    chk("sub_valE", bus.valE, 32'h7FFF_FFFF);
    chk("sub_cc", {29'd0, cc}, 32'h1);
    send(4'd0, 4'd2, 1'b0, 32'd0, 32'd0, 32'd0, 4'd5, 4'd6);
    @(negedge clock); #1;
    chk("cond_l", {31'd0, bus.cnd}, 32'd1);

    // Backpressure: second ADD blocked until the held entry is consumed
    @(negedge clock);
    bus.out_ready = 1'b0;
    send(4'd0, 4'd0, 1'b0, 32'd1, 32'd2, 32'd0, 4'd7, 4'd8);
    drive(4'd0, 4'd0, 1'b0, 32'd10, 32'd20, 32'd0, 4'd9, 4'd10);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_valE", bus.valE, 32'd3);
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    model_accept(4'd0, 4'd0, 1'b0, 32'd10, 32'd20, 32'd0, 4'd9, 4'd10);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(negedge clock); #1;
    chk("bp_second_valE", bus.valE, 32'd30);

    // Multiply latency
    send(4'd5, 4'd0, 1'b1, 32'd6, 32'hFFFF_FFFF, 32'd0, 4'd11, 4'd12);
`ifdef EXE_MUL_EN
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock); #1;
      chk("mul_out_valid", {31'd0, bus.out_valid}, {31'd0, (k == 34)});
      if (k == 1 || k == 33) chk("mul_busy", {31'd0, busy}, 32'd1);
      if (k == 34) chk("mul_valE", bus.valE, 32'hFFFF_FFFA);
    end
`else
    @(negedge clock); #1;
    chk("rsv5_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rsv5_valE", bus.valE, 32'd0);
    chk("rsv5_busy", {31'd0, busy}, 32'd0);
`endif

    // Reset ten cycles into a multiply
    send(4'd5, 4'd0, 1'b1, 32'd3, 32'd4, 32'd0, 4'd1, 4'd1);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1 check_reset_values("midrst");
    sb.delete();
    mcc = 3'b100;
    @(negedge clock);
    reset = 1'b1;
    #1 chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (40) @(negedge clock);
    #1 chk("midrst_no_entry", {31'd0, bus.out_valid}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      working = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_valid = $urandom_range(0, 1);
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            rnd32(), rnd32(), rnd32(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      if (bus.in_valid && bus.in_ready)
        model_accept(bus.alufun, bus.cond, bus.set_cc, bus.valA, bus.valB, bus.valC,
                     bus.dstE_in, bus.dstM_in);
    end

    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock); n++;
    end
    chk("drain_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
